// File: rtl/mul_seq_ctrl.sv
// Iterative radix-2 multiply / multiply-accumulate sequencer that owns the HI/LO register pair.
// Requests arrive over valid/ready; the issuing stage is held off while a product is in flight.
module mul_seq_ctrl #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter logic [2:0]  MADD      = 3'b000,
    parameter logic [2:0]  MADDU     = 3'b001,
    parameter logic [2:0]  MUL       = 3'b010,
    parameter logic [2:0]  MFLO      = 3'b100,
    parameter logic [2:0]  MFHI      = 3'b101
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           mul_op,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    output logic [BUS_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PW = 2 * BUS_WIDTH;
    localparam int unsigned CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BUS_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCommit
    } state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] hi_q, hi_d;
    logic [BUS_WIDTH-1:0] lo_q, lo_d;
    logic [BUS_WIDTH-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [PW-1:0]        mcand_q, mcand_d;
    logic [BUS_WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic                 accum_q, accum_d;

    logic                 accept;
    logic [BUS_WIDTH-1:0] in1_mag;
    logic [BUS_WIDTH-1:0] in2_mag;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        addend;
    logic [PW-1:0]        sum;

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StCommit) && !flush;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign accept    = req_valid && req_ready;

    // The most-negative value negates to itself, which read unsigned is exactly 2^(W-1).
    assign in1_mag = in1[BUS_WIDTH-1] ? -in1 : in1;
    assign in2_mag = in2[BUS_WIDTH-1] ? -in2 : in2;

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        addend = accum_q ? {hi_q, lo_q} : '0;
        sum    = prod + addend;
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        neg_d       = neg_q;
        accum_d     = accum_q;

        if (flush && (state_q != StIdle)) begin
            // Abort wins over the commit write; HI/LO keep their old contents.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (mul_op)
                            MUL, MADD: begin
                                mcand_d  = {{BUS_WIDTH{1'b0}}, in1_mag};
                                mplier_d = in2_mag;
                                neg_d    = in1[BUS_WIDTH-1] ^ in2[BUS_WIDTH-1];
                                accum_d  = (mul_op == MADD);
                                acc_d    = '0;
                                count_d  = '0;
                                state_d  = StRun;
                            end
                            MADDU: begin
                                mcand_d  = {{BUS_WIDTH{1'b0}}, in1};
                                mplier_d = in2;
                                neg_d    = 1'b0;
                                accum_d  = 1'b1;
                                acc_d    = '0;
                                count_d  = '0;
                                state_d  = StRun;
                            end
                            MFLO: begin
                                out_d       = lo_q;
                                out_valid_d = 1'b1;
                            end
                            MFHI: begin
                                out_d       = hi_q;
                                out_valid_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    // mcand_q already carries the shift by count, mplier_q[0] is bit count.
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == CNT_LAST) begin
                        state_d = StCommit;
                    end
                end
                StCommit: begin
                    {hi_d, lo_d} = sum;
                    state_d      = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hi_q        <= '0;
            lo_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            neg_q       <= 1'b0;
            accum_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
            neg_q       <= neg_d;
            accum_q     <= accum_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a plain-arithmetic HI/LO model.
module tb_mul_seq_ctrl;

    localparam int W = 32;
    localparam logic [2:0] OP_MADD  = 3'b000;
    localparam logic [2:0] OP_MADDU = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_BAD3  = 3'b011;
    localparam logic [2:0] OP_MFLO  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_BAD7  = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   mul_op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] out;
    logic         out_valid;
    logic         busy;
    logic         done;

    int           checks   = 0;
    int           failures = 0;
    logic [63:0]  model;
    logic [W-1:0] last_rd;

    typedef struct packed {
        logic        rst;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [0:9];

    always #5 clk = ~clk;

    mul_seq_ctrl #(.BUS_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mul_op    (mul_op),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: HI/LO after one operation, straight from the arithmetic definition.
    function automatic logic [63:0] ref_step(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [63:0] acc);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MUL:   return 64'(sa * sb);
            OP_MADD:  return acc + 64'(sa * sb);
            OP_MADDU: return acc + ua * ub;
            default:  return acc;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present a request at a negedge, hold it until accepted; returns at the negedge after accept.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n         = 0;
        req_valid = 1'b1;
        mul_op    = op;
        in1       = a;
        in2       = b;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [2:0] op, input logic [W-1:0] exp);
        send(op, $urandom, $urandom);
        chk({name, "_vld"}, 64'(out_valid), 64'd1);
        chk(name, 64'(out), 64'(exp));
        last_rd = exp;
    endtask

    task automatic check_hilo(input string name, input logic [63:0] exp);
        read_chk({name, "_hi"}, OP_MFHI, exp[63:32]);
        read_chk({name, "_lo"}, OP_MFLO, exp[31:0]);
    endtask

    // lat counts the negedge on which done is seen, the first negedge after accept being 1.
    task automatic run_mul(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat);
        send(op, a, b);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("ready_after_commit", 64'(req_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        @(negedge clk);
        model   = '0;
        last_rd = '0;
    endtask

    initial begin
        int          lat;
        int          lowcnt;
        int          n;
        logic        saw;
        logic [2:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0] = '{1'b0, OP_MUL,   32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
        vecs[1] = '{1'b0, OP_MADD,  32'h80000000, 32'h80000000, 64'h3FFFFFFF_FFFFFFEB};
        vecs[2] = '{1'b1, OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[3] = '{1'b0, OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFC_00000002};
        vecs[4] = '{1'b0, OP_MUL,   32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
        vecs[5] = '{1'b0, OP_MUL,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
        vecs[6] = '{1'b0, OP_MUL,   32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
        vecs[7] = '{1'b0, OP_MADD,  32'hFFFFFFFF, 32'h00000001, 64'h3FFFFFFF_00000000};
        vecs[8] = '{1'b0, OP_MUL,   32'h00000000, 32'hDEADBEEF, 64'h00000000_00000000};
        vecs[9] = '{1'b0, OP_MADDU, 32'h00010000, 32'h00010000, 64'h00000001_00000000};

        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        mul_op    = 3'b000;
        in1       = '0;
        in2       = '0;
        model     = '0;
        last_rd   = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back MFHI then MFLO straight out of reset.
        req_valid = 1'b1;
        mul_op    = OP_MFHI;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_hi_vld", 64'(out_valid), 64'd1);
        chk("b2b_hi", 64'(out), 64'd0);
        mul_op = OP_MFLO;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_lo_vld", 64'(out_valid), 64'd1);
        chk("b2b_lo", 64'(out), 64'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_vld_drop", 64'(out_valid), 64'd0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) do_reset();
            run_mul(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
            model = vecs[i].exp;
            check_hilo($sformatf("vec%0d", i), vecs[i].exp);
        end

        // MFHI held during a multiply: stalls BUS_WIDTH+1 cycles, then returns the new HI.
        send(OP_MUL, 32'h12345678, 32'hFEDCBA98);
        model     = ref_step(OP_MUL, 32'h12345678, 32'hFEDCBA98, model);
        req_valid = 1'b1;
        mul_op    = OP_MFHI;
        lowcnt    = 0;
        n         = 0;
        saw       = 1'b0;
        while (!req_ready && n < 200) begin
            saw = saw | done;
            lowcnt++;
            in1 = $urandom;
            in2 = $urandom;
            @(negedge clk);
            n++;
        end
        chk("hold_stall_cycles", 64'(lowcnt), 64'(W + 1));
        chk("hold_done_seen", 64'(saw), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_rd_vld", 64'(out_valid), 64'd1);
        chk("hold_rd_hi", 64'(out), 64'(model[63:32]));
        last_rd = model[63:32];

        // Flush at RUN cycle 10.
        send(OP_MUL, 32'd1234, 32'd5678);
        saw = 1'b0;
        repeat (9) begin
            saw = saw | done;
            @(negedge clk);
        end
        flush = 1'b1;
        chk("flush_run_busy", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_run_ready", 64'(req_ready), 64'd1);
        chk("flush_run_idle", 64'(busy), 64'd0);
        repeat (40) begin
            saw = saw | done;
            @(negedge clk);
        end
        chk("flush_run_no_done", 64'(saw), 64'd0);
        check_hilo("flush_run", model);

        // Flush landing in the COMMIT cycle beats the write.
        send(OP_MADD, 32'd9, 32'd9);
        repeat (W) @(negedge clk);
        chk("commit_done_pre_flush", 64'(done), 64'd1);
        flush = 1'b1;
        #1;
        chk("commit_done_killed", 64'(done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_commit_ready", 64'(req_ready), 64'd1);
        check_hilo("flush_commit", model);

        // Flush while idle is ignored.
        flush = 1'b1;
        read_chk("flush_idle_lo", OP_MFLO, model[31:0]);
        flush = 1'b0;

        // Undefined opcodes are consumed in one cycle with no visible effect.
        send(OP_BAD7, $urandom, $urandom);
        chk("bad7_no_vld", 64'(out_valid), 64'd0);
        chk("bad7_out_held", 64'(out), 64'(last_rd));
        chk("bad7_ready", 64'(req_ready), 64'd1);
        chk("bad7_busy", 64'(busy), 64'd0);
        send(OP_BAD3, $urandom, $urandom);
        chk("bad3_no_vld", 64'(out_valid), 64'd0);
        chk("bad3_busy", 64'(busy), 64'd0);
        check_hilo("bad_op", model);

        // Asynchronous reset in the middle of RUN.
        run_mul(OP_MUL, 32'd5, 32'd7, lat);
        model = ref_step(OP_MUL, 32'd5, 32'd7, model);
        read_chk("pre_rst_lo", OP_MFLO, model[31:0]);
        send(OP_MUL, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_out", 64'(out), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        model   = '0;
        last_rd = '0;
        @(negedge clk);
        check_hilo("midrst", model);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0:       op = OP_MUL;
                1:       op = OP_MADD;
                2:       op = OP_MADDU;
                3:       op = OP_MFHI;
                4:       op = OP_MFLO;
                5:       op = OP_BAD7;
                default: op = 3'b110;
            endcase
            a = pick();
            b = pick();
            if (op == OP_MUL || op == OP_MADD || op == OP_MADDU) begin
                run_mul(op, a, b, lat);
                chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(W + 1));
                model = ref_step(op, a, b, model);
                check_hilo($sformatf("rnd%0d", i), model);
            end else if (op == OP_MFHI) begin
                read_chk($sformatf("rnd%0d_mfhi", i), op, model[63:32]);
            end else if (op == OP_MFLO) begin
                read_chk($sformatf("rnd%0d_mflo", i), op, model[31:0]);
            end else begin
                send(op, a, b);
                chk($sformatf("rnd%0d_bad_no_vld", i), 64'(out_valid), 64'd0);
                chk($sformatf("rnd%0d_bad_out", i), 64'(out), 64'(last_rd));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
